// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
// Shared types for the NPC memory-access path.
//   arb_state_e : mem_arbiter FSM states
//   OWNER_*     : requester ids used as the arbiter owner / last-grant value
// -----------------------------------------------------------------------------
package npc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. When both requesters are active, the one that
// was NOT granted last wins; a lone requester always wins.
// Ports:
//   req  in  2  request vector, bit 0 = IFU, bit 1 = LSU
//   last in  1  owner id of the previous grant (OWNER_IFU / OWNER_LSU)
//   gnt  out 2  one-hot grant (or zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arb2
    import npc_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWNER_IFU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single pmem port between IFU (read-only) and LSU (read/write).
// One access is outstanding at a time; a down-counter stretches the ACCESS
// phase to LATENCY cycles to model slow memory.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no access in flight; ready offered to the arbitration winner
//   ACCESS | strobe issued on the first cycle, counter runs down to zero
//   RESP   | owner's resp_valid high, rdata held until resp_ready
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   ifu_req_valid/ready, ifu_addr     IFU request channel
//   ifu_resp_valid/ready, ifu_rdata   IFU response channel
//   lsu_req_valid/ready, lsu_wen,
//   lsu_addr, lsu_wdata, lsu_wmask    LSU request channel
//   lsu_resp_valid/ready, lsu_rdata   LSU response channel (rdata 0 on stores)
//   mem_ren, mem_wen                  single-cycle strobes to the memory port
//   mem_raddr, mem_waddr, mem_wdata,
//   mem_wmask                         latched request fields
//   mem_rdata                         combinational read data (mem_ren cycle)
// -----------------------------------------------------------------------------
module mem_arbiter
    import npc_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [DW-1:0] ifu_rdata,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_wen,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [DW-1:0] lsu_rdata,

    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic [DW-1:0] mem_rdata
);

    // Counter only needs to hold LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    arb_state_e    state_q, state_d;
    logic          owner_q;
    logic          last_q;
    logic          wen_q;
    logic          first_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    wmask_q;
    logic [DW-1:0] ifu_rdata_q;
    logic [DW-1:0] lsu_rdata_q;

    logic [1:0]    gnt;
    logic          grant;
    logic          resp_hs;

    rr_arb2 u_rr_arb2 (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    // Grants are only honoured while idle; gnt itself is free-running.
    assign grant = (state_q == IDLE) && (gnt != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        resp_hs        = 1'b0;
        case (state_q)
            IDLE: begin
                ifu_req_ready = gnt[0];
                lsu_req_ready = gnt[1];
                if (gnt != 2'b00) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_ren = first_q & ~wen_q;
                mem_wen = first_q &  wen_q;
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ifu_resp_valid = (owner_q == OWNER_IFU);
                lsu_resp_valid = (owner_q == OWNER_LSU);
                resp_hs = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWNER_IFU;
            last_q      <= OWNER_IFU;
            wen_q       <= 1'b0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= gnt[1] ? OWNER_LSU : OWNER_IFU;
                last_q  <= gnt[1] ? OWNER_LSU : OWNER_IFU;
                wen_q   <= gnt[1] & lsu_wen;
                addr_q  <= gnt[1] ? lsu_addr  : ifu_addr;
                wdata_q <= gnt[1] ? lsu_wdata : '0;
                wmask_q <= gnt[1] ? lsu_wmask : 8'h00;
                cnt_q   <= CW'(LATENCY - 1);
                first_q <= 1'b1;
            end else if (state_q == ACCESS) begin
                first_q <= 1'b0;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end

            // Read data is only valid during the strobe cycle, so capture it there.
            if (mem_ren) begin
                if (owner_q == OWNER_LSU) begin
                    lsu_rdata_q <= mem_rdata;
                end else begin
                    ifu_rdata_q <= mem_rdata;
                end
            end
            if (mem_wen) begin
                lsu_rdata_q <= '0;
            end
        end
    end

    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule
